// File: rtl/video_pattern_gen_if.sv
// Bundle between the video pattern generator and its consumer: runtime
// configuration flows into the generator, timing strobes and pixels flow out.
interface video_pattern_gen_if #(
  parameter int CW  = 12,
  parameter int DW  = 8,
  parameter int FCW = 16
);
  logic [2:0]     mode;
  logic [DW-1:0]  single_r;
  logic [DW-1:0]  single_g;
  logic [DW-1:0]  single_b;
  logic [CW-1:0]  h_total;
  logic [CW-1:0]  h_sync;
  logic [CW-1:0]  h_bporch;
  logic [CW-1:0]  h_res;
  logic [CW-1:0]  v_total;
  logic [CW-1:0]  v_sync;
  logic [CW-1:0]  v_bporch;
  logic [CW-1:0]  v_res;
  logic           hs_pol;
  logic           vs_pol;

  logic           de;
  logic           hs;
  logic           vs;
  logic [DW-1:0]  data_r;
  logic [DW-1:0]  data_g;
  logic [DW-1:0]  data_b;
  logic           frame_start;
  logic           line_start;
  logic [FCW-1:0] frame_cnt;

  modport master (
    input  mode, single_r, single_g, single_b,
    input  h_total, h_sync, h_bporch, h_res,
    input  v_total, v_sync, v_bporch, v_res,
    input  hs_pol, vs_pol,
    output de, hs, vs, data_r, data_g, data_b,
    output frame_start, line_start, frame_cnt
  );

  modport slave (
    output mode, single_r, single_g, single_b,
    output h_total, h_sync, h_bporch, h_res,
    output v_total, v_sync, v_bporch, v_res,
    output hs_pol, vs_pol,
    input  de, hs, vs, data_r, data_g, data_b,
    input  frame_start, line_start, frame_cnt
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source. Configuration is shadowed and only
// taken over at the end of a frame; all outputs are registered one cycle
// behind the horizontal/vertical counters.
module video_pattern_gen #(
  parameter int CW  = 12,
  parameter int DW  = 8,
  parameter int FCW = 16,
  parameter int GS  = 5
) (
  input logic                 clk,
  input logic                 reset_n,
  video_pattern_gen_if.master vif
);

  localparam logic [CW-1:0] CW_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CW_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] BLACK   = {DW{1'b0}};
  localparam logic [DW-1:0] WHITE   = {DW{1'b1}};

  // Full-scale {R,G,B} on/off bits of each colour bar, left to right.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  // Shadow copies of the configuration
  logic [2:0]     mode_r;
  logic [DW-1:0]  sr_r, sg_r, sb_r;
  logic [CW-1:0]  h_total_r, h_sync_r, h_bporch_r, h_res_r;
  logic [CW-1:0]  v_total_r, v_sync_r, v_bporch_r, v_res_r;
  logic           hs_pol_r, vs_pol_r;

  logic [CW-1:0]  h_cnt_r, v_cnt_r;
  logic [FCW-1:0] frame_cnt_r;
  logic [CW-1:0]  bar_pos_r;
  logic [2:0]     bar_idx_r;

  logic           de_r, hs_r, vs_r, fs_r, ls_r;
  logic [DW-1:0]  data_r_r, data_g_r, data_b_r;

  logic           h_wrap_s, v_last_s, eof_s;
  logic [CW:0]    h_start_s, v_start_s;
  logic [CW+1:0]  h_end_s, v_end_s;
  logic           h_in_s, de_h_s, de_v_s, hs_a_s, vs_a_s;
  logic [CW-1:0]  x_s;
  logic [GS:0]    y_s;
  logic [CW-1:0]  bar_w_s;
  logic [2:0]     rgb_s;
  logic [DW-1:0]  pix_r_s, pix_g_s, pix_b_s;

  // Configuration is taken over during reset and on the last cycle of a frame
  always_ff @(posedge clk) begin
    if (!reset_n || eof_s) begin
      mode_r     <= vif.mode;
      sr_r       <= vif.single_r;
      sg_r       <= vif.single_g;
      sb_r       <= vif.single_b;
      h_total_r  <= vif.h_total;
      h_sync_r   <= vif.h_sync;
      h_bporch_r <= vif.h_bporch;
      h_res_r    <= vif.h_res;
      v_total_r  <= vif.v_total;
      v_sync_r   <= vif.v_sync;
      v_bporch_r <= vif.v_bporch;
      v_res_r    <= vif.v_res;
      hs_pol_r   <= vif.hs_pol;
      vs_pol_r   <= vif.vs_pol;
    end
  end

  // Line and frame end detection from the shadowed totals
  always_comb begin
    h_wrap_s = (h_cnt_r == (h_total_r - CW_ONE));
    v_last_s = (v_cnt_r == (v_total_r - CW_ONE));
    eof_s    = h_wrap_s && v_last_s;
  end

  // Pixel/line counters and the completed-frame counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_r     <= CW_ZERO;
      v_cnt_r     <= CW_ZERO;
      frame_cnt_r <= {FCW{1'b0}};
    end else begin
      if (h_wrap_s) begin
        h_cnt_r <= CW_ZERO;
        if (v_last_s) begin
          v_cnt_r <= CW_ZERO;
        end else begin
          v_cnt_r <= v_cnt_r + CW_ONE;
        end
      end else begin
        h_cnt_r <= h_cnt_r + CW_ONE;
      end
      if (eof_s) begin
        frame_cnt_r <= frame_cnt_r + {{(FCW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Sync and active-window decode; window sums are widened so they never wrap
  always_comb begin
    h_start_s = {1'b0, h_sync_r} + {1'b0, h_bporch_r};
    v_start_s = {1'b0, v_sync_r} + {1'b0, v_bporch_r};
    h_end_s   = {2'b00, h_sync_r} + {2'b00, h_bporch_r} + {2'b00, h_res_r};
    v_end_s   = {2'b00, v_sync_r} + {2'b00, v_bporch_r} + {2'b00, v_res_r};
    h_in_s    = ({1'b0, h_cnt_r} >= h_start_s);
    de_h_s    = h_in_s && ({2'b00, h_cnt_r} < h_end_s);
    de_v_s    = ({1'b0, v_cnt_r} >= v_start_s) && ({2'b00, v_cnt_r} < v_end_s);
    x_s       = h_cnt_r - h_start_s[CW-1:0];
    y_s       = v_cnt_r[GS:0] - v_start_s[GS:0];
    hs_a_s    = (h_cnt_r < h_sync_r);
    vs_a_s    = (v_cnt_r < v_sync_r);
    if ((h_res_r >> 3'd3) == CW_ZERO) begin
      bar_w_s = CW_ONE;
    end else begin
      bar_w_s = h_res_r >> 3'd3;
    end
  end

  // Colour-bar position tracker: restarts before every active line, saturates at bar 7
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bar_pos_r <= CW_ZERO;
      bar_idx_r <= 3'd0;
    end else if (h_wrap_s || !h_in_s) begin
      bar_pos_r <= CW_ZERO;
      bar_idx_r <= 3'd0;
    end else if (bar_pos_r == (bar_w_s - CW_ONE)) begin
      bar_pos_r <= CW_ZERO;
      if (bar_idx_r != 3'd7) begin
        bar_idx_r <= bar_idx_r + 3'd1;
      end
    end else begin
      bar_pos_r <= bar_pos_r + CW_ONE;
    end
  end

  // Pattern selection; pixels are forced black outside the active window
  always_comb begin
    pix_r_s = BLACK;
    pix_g_s = BLACK;
    pix_b_s = BLACK;
    rgb_s   = bar_rgb(bar_idx_r);
    if (de_h_s && de_v_s) begin
      case (mode_r)
        3'd0: begin
          pix_r_s = {DW{rgb_s[2]}};
          pix_g_s = {DW{rgb_s[1]}};
          pix_b_s = {DW{rgb_s[0]}};
        end
        3'd1: begin
          if ((x_s[GS-1:0] == {GS{1'b0}}) || (y_s[GS-1:0] == {GS{1'b0}})) begin
            pix_r_s = WHITE;
            pix_g_s = WHITE;
            pix_b_s = WHITE;
          end else begin
            pix_r_s = BLACK;
            pix_g_s = BLACK;
            pix_b_s = BLACK;
          end
        end
        3'd2: begin
          pix_r_s = DW'(x_s);
          pix_g_s = DW'(x_s);
          pix_b_s = DW'(x_s);
        end
        3'd3: begin
          pix_r_s = sr_r;
          pix_g_s = sg_r;
          pix_b_s = sb_r;
        end
        3'd4: begin
          pix_r_s = DW'(x_s) + DW'(frame_cnt_r);
          pix_g_s = DW'(x_s) + DW'(frame_cnt_r);
          pix_b_s = DW'(x_s) + DW'(frame_cnt_r);
        end
        3'd5: begin
          if (x_s[GS] ^ y_s[GS]) begin
            pix_r_s = WHITE;
            pix_g_s = WHITE;
            pix_b_s = WHITE;
          end else begin
            pix_r_s = BLACK;
            pix_g_s = BLACK;
            pix_b_s = BLACK;
          end
        end
        default: begin
          pix_r_s = BLACK;
          pix_g_s = BLACK;
          pix_b_s = BLACK;
        end
      endcase
    end else begin
      pix_r_s = BLACK;
      pix_g_s = BLACK;
      pix_b_s = BLACK;
    end
  end

  // Output register stage: everything lags the counters by one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      de_r     <= 1'b0;
      hs_r     <= 1'b0;
      vs_r     <= 1'b0;
      fs_r     <= 1'b0;
      ls_r     <= 1'b0;
      data_r_r <= BLACK;
      data_g_r <= BLACK;
      data_b_r <= BLACK;
    end else begin
      de_r     <= de_h_s && de_v_s;
      hs_r     <= ~(hs_a_s ^ hs_pol_r);
      vs_r     <= ~(vs_a_s ^ vs_pol_r);
      ls_r     <= (h_cnt_r == CW_ZERO);
      fs_r     <= (h_cnt_r == CW_ZERO) && (v_cnt_r == CW_ZERO);
      data_r_r <= pix_r_s;
      data_g_r <= pix_g_s;
      data_b_r <= pix_b_s;
    end
  end

  assign vif.de          = de_r;
  assign vif.hs          = hs_r;
  assign vif.vs          = vs_r;
  assign vif.frame_start = fs_r;
  assign vif.line_start  = ls_r;
  assign vif.data_r      = data_r_r;
  assign vif.data_g      = data_g_r;
  assign vif.data_b      = data_b_r;
  assign vif.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: every output cycle is compared
// against a frame-position reference model, plus a pattern vector table and
// hand-written sequences for polarity, shadowing, wrap and mid-line reset.
module tb_video_pattern_gen;
  localparam int CW  = 12;
  localparam int DW  = 8;
  localparam int FCW = 2;
  localparam int GS  = 2;

  typedef struct {
    int mode, sr, sg, sb;
    int ht, hs, hb, hr;
    int vt, vs, vb, vr;
    int hp, vp;
  } cfg_t;

  typedef struct {
    int mode;
    int x;
    int y;
    int rgb;
  } pat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  cfg_t drv;   // what the bench currently drives
  cfg_t act;   // configuration the model believes the frame is using
  int   t;     // cycle position inside the current frame
  int   fc;    // completed frames modulo 2^FCW

  always #5 clk = ~clk;

  video_pattern_gen_if #(.CW(CW), .DW(DW), .FCW(FCW)) vif ();

  video_pattern_gen #(.CW(CW), .DW(DW), .FCW(FCW), .GS(GS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vif     (vif)
  );

  function automatic int ref_pix(cfg_t c, int x, int y, int f);
    int tab [8];
    int w, b;
    tab = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF, 32'h00FF00,
            32'hFF00FF, 32'hFF0000, 32'h0000FF, 32'h000000};
    case (c.mode)
      0: begin
        w = c.hr / 8;
        if (w == 0) w = 1;
        b = x / w;
        if (b > 7) b = 7;
        return tab[b];
      end
      1: return (((x % (1 << GS)) == 0) || ((y % (1 << GS)) == 0)) ? 32'hFFFFFF : 32'h0;
      2: return (x % 256) * 32'h010101;
      3: return (c.sr << 16) | (c.sg << 8) | c.sb;
      4: return ((x + f) % 256) * 32'h010101;
      5: return ((((x >> GS) ^ (y >> GS)) & 1) != 0) ? 32'hFFFFFF : 32'h0;
      default: return 0;
    endcase
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.mode = $urandom_range(0, 7);
    c.sr = $urandom_range(0, 255);
    c.sg = $urandom_range(0, 255);
    c.sb = $urandom_range(0, 255);
    c.ht = $urandom_range(2, 30);
    c.hs = $urandom_range(0, 8);
    c.hb = $urandom_range(0, 6);
    c.hr = $urandom_range(0, 30);
    c.vt = $urandom_range(1, 7);
    c.vs = $urandom_range(0, 3);
    c.vb = $urandom_range(0, 2);
    c.vr = $urandom_range(0, 6);
    c.hp = $urandom_range(0, 1);
    c.vp = $urandom_range(0, 1);
    return c;
  endfunction

  task automatic apply_cfg(input cfg_t c);
    drv = c;
    vif.mode     = 3'(c.mode);
    vif.single_r = DW'(c.sr);
    vif.single_g = DW'(c.sg);
    vif.single_b = DW'(c.sb);
    vif.h_total  = CW'(c.ht);
    vif.h_sync   = CW'(c.hs);
    vif.h_bporch = CW'(c.hb);
    vif.h_res    = CW'(c.hr);
    vif.v_total  = CW'(c.vt);
    vif.v_sync   = CW'(c.vs);
    vif.v_bporch = CW'(c.vb);
    vif.v_res    = CW'(c.vr);
    vif.hs_pol   = c.hp[0];
    vif.vs_pol   = c.vp[0];
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: sample #1 after the edge and compare every output with the model
  task automatic step();
    cfg_t snap;
    logic rst_v;
    int h, v, hst, vst, ed, ehs, evs, efs, els, efc, epx, got_px;
    snap  = drv;
    rst_v = reset_n;
    @(posedge clk);
    #1;
    if (!rst_v) begin
      ed = 0; ehs = 0; evs = 0; efs = 0; els = 0; epx = 0; efc = 0;
      act = snap; t = 0; fc = 0;
    end else begin
      h   = t % act.ht;
      v   = t / act.ht;
      hst = act.hs + act.hb;
      vst = act.vs + act.vb;
      ed  = int'((h >= hst) && (h < hst + act.hr) && (v >= vst) && (v < vst + act.vr));
      ehs = int'((h < act.hs) == (act.hp != 0));
      evs = int'((v < act.vs) == (act.vp != 0));
      els = int'(h == 0);
      efs = int'(t == 0);
      epx = (ed != 0) ? ref_pix(act, h - hst, v - vst, fc) : 0;
      if (t == act.ht * act.vt - 1) begin
        act = snap;
        fc  = (fc + 1) % (1 << FCW);
        t   = 0;
      end else begin
        t++;
      end
      efc = fc;
    end
    got_px = int'({vif.data_r, vif.data_g, vif.data_b});
    total++;
    if (vif.de !== ed[0] || vif.hs !== ehs[0] || vif.vs !== evs[0] ||
        vif.frame_start !== efs[0] || vif.line_start !== els[0] ||
        got_px != epx || int'(vif.frame_cnt) != efc) begin
      bad++;
      $display("FAIL model t=%0t got de%0b hs%0b vs%0b fs%0b ls%0b px%06h fc%0d expected de%0d hs%0d vs%0d fs%0d ls%0d px%06h fc%0d",
               $time, vif.de, vif.hs, vif.vs, vif.frame_start, vif.line_start, got_px,
               vif.frame_cnt, ed, ehs, evs, efs, els, epx, efc);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  task automatic count_run(input int n, input int start, output int c_hs, output int c_vs,
                           output int c_de, output int c_fs, output int c_ls, output int first_de);
    c_hs = 0; c_vs = 0; c_de = 0; c_fs = 0; c_ls = 0; first_de = -1;
    for (int i = 0; i < n; i++) begin
      step();
      c_hs += int'(vif.hs);
      c_vs += int'(vif.vs);
      c_de += int'(vif.de);
      c_fs += int'(vif.frame_start);
      c_ls += int'(vif.line_start);
      if (vif.de && first_de < 0) first_de = start + i;
    end
  endtask

  initial begin
    cfg_t s, p, c;
    pat_t pats [16];
    int c_hs, c_vs, c_de, c_fs, c_ls, fde, n, k, errs, found;

    s = '{mode: 2, sr: 0, sg: 0, sb: 0, ht: 10, hs: 2, hb: 1, hr: 6,
          vt: 5, vs: 1, vb: 1, vr: 2, hp: 1, vp: 1};
    p = '{mode: 0, sr: 0, sg: 0, sb: 0, ht: 80, hs: 4, hb: 4, hr: 64,
          vt: 4, vs: 1, vb: 1, vr: 2, hp: 1, vp: 1};
    pats = '{
      '{0, 0, 0, 32'hFFFFFF}, '{0, 7, 0, 32'hFFFFFF}, '{0, 8, 0, 32'hFFFF00},
      '{0, 16, 1, 32'h00FFFF}, '{0, 24, 0, 32'h00FF00}, '{0, 32, 0, 32'hFF00FF},
      '{0, 40, 1, 32'hFF0000}, '{0, 48, 0, 32'h0000FF}, '{0, 63, 0, 32'h000000},
      '{2, 37, 1, 32'h252525}, '{2, 63, 0, 32'h3F3F3F}, '{1, 4, 1, 32'hFFFFFF},
      '{1, 5, 1, 32'h000000}, '{5, 4, 1, 32'hFFFFFF}, '{5, 1, 1, 32'h000000},
      '{6, 3, 0, 32'h000000}};

    // Reset state and small timing
    apply_cfg(s);
    do_reset(3);
    chk("reset_de", int'(vif.de), 0);
    chk("reset_hs", int'(vif.hs), 0);
    step();
    chk("first_fs", int'(vif.frame_start), 1);
    chk("first_ls", int'(vif.line_start), 1);
    chk("first_hs", int'(vif.hs), 1);
    chk("first_vs", int'(vif.vs), 1);
    chk("first_de", int'(vif.de), 0);
    count_run(50, 1, c_hs, c_vs, c_de, c_fs, c_ls, fde);
    chk("hs_high_cnt", c_hs, 10);
    chk("vs_high_cnt", c_vs, 10);
    chk("de_cnt", c_de, 12);
    chk("fs_cnt", c_fs, 1);
    chk("ls_cnt", c_ls, 5);
    chk("first_de_idx", fde, 23);

    // Negative polarity
    c = s; c.hp = 0; c.vp = 0;
    apply_cfg(c);
    do_reset(2);
    step();
    chk("pol_first_hs", int'(vif.hs), 0);
    count_run(50, 1, c_hs, c_vs, c_de, c_fs, c_ls, fde);
    chk("pol_hs_high", c_hs, 40);
    chk("pol_vs_high", c_vs, 40);
    chk("pol_de_cnt", c_de, 12);

    // Mid-frame configuration change waits for the frame boundary
    apply_cfg(s);
    do_reset(2);
    step();
    repeat (20) step();
    c = s; c.ht = 12; c.mode = 3; c.sr = 8'h12; c.sg = 8'h34; c.sb = 8'h56;
    apply_cfg(c);
    n = 0;
    while (n < 200) begin step(); n++; if (vif.frame_start) break; end
    chk("shadow_frame_idx", 20 + n, 50);
    n = 0;
    while (n < 200) begin step(); n++; if (vif.line_start) break; end
    chk("shadow_line_period", n, 12);
    found = 0;
    for (int j = 0; j < 200; j++) begin step(); if (vif.de) begin found = 1; break; end end
    chk("shadow_de_found", found, 1);
    chk("shadow_solid", int'({vif.data_r, vif.data_g, vif.data_b}), 32'h123456);

    // Pattern vector table
    for (int i = 0; i < 16; i++) begin
      c = p; c.mode = pats[i].mode;
      apply_cfg(c);
      do_reset(2);
      k = (2 + pats[i].y) * 80 + 8 + pats[i].x;
      repeat (k + 1) step();
      chk($sformatf("pat%0d_m%0d_x%0d", i, pats[i].mode, pats[i].x),
          int'({vif.data_r, vif.data_g, vif.data_b}), pats[i].rgb);
    end

    // Horizontal gradient across a whole line
    c = p; c.mode = 2;
    apply_cfg(c);
    do_reset(2);
    found = 0;
    for (int j = 0; j < 400; j++) begin step(); if (vif.de) begin found = 1; break; end end
    chk("grad_de_found", found, 1);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (int'(vif.data_r) != i) errs++;
      step();
    end
    chk("grad_line_errs", errs, 0);
    chk("grad_de_end", int'(vif.de), 0);

    // Moving gradient and frame counter wrap over five frames
    c = p; c.mode = 4;
    apply_cfg(c);
    do_reset(2);
    for (int f = 0; f < 5; f++) begin
      found = 0;
      for (int j = 0; j < 400; j++) begin step(); if (vif.de) begin found = 1; break; end end
      chk($sformatf("move_found_f%0d", f), found, 1);
      chk($sformatf("move_pix_f%0d", f), int'(vif.data_r), f % 4);
      chk($sformatf("move_fcnt_f%0d", f), int'(vif.frame_cnt), f % 4);
      for (int j = 0; j < 400; j++) begin step(); if (vif.frame_start) break; end
    end

    // Reset pulled mid-line in the second frame
    apply_cfg(s);
    do_reset(2);
    repeat (75) step();
    chk("mid_pre_fcnt", int'(vif.frame_cnt), 1);
    chk("mid_pre_de", int'(vif.de), 1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_de", int'(vif.de), 0);
    chk("mid_rst_data", int'(vif.data_r), 0);
    chk("mid_rst_fcnt", int'(vif.frame_cnt), 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("mid_rel_fs", int'(vif.frame_start), 1);
    chk("mid_rel_ls", int'(vif.line_start), 1);
    chk("mid_rel_hs", int'(vif.hs), 1);
    chk("mid_rel_fcnt", int'(vif.frame_cnt), 0);

    // Randomized configurations with random mid-frame changes
    for (int r = 0; r < 24; r++) begin
      c = rand_cfg();
      apply_cfg(c);
      if (r % 3 == 0) do_reset($urandom_range(1, 3));
      n = c.ht * c.vt * 2 + $urandom_range(0, 50);
      for (int j = 0; j < n; j++) begin
        step();
        if ($urandom_range(0, 99) == 0) apply_cfg(rand_cfg());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
